l2_arbiter: RTL and testbench



---
 rtl/l2_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_l2_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// l2_arbiter
// Multiplexes the L1 instruction cache and the L1 data cache onto the single
// line-wide L2 request port. A grant latches the winner's request and holds it
// unchanged on the L2 port until mem_resp. The read data is then returned to
// the winner together with a one-cycle resp pulse.
//
// Build option: define L2_ARB_ROUND_ROBIN_EN to alternate grants when I and D
// request in the same cycle. Without it, D always wins over I.
// A single requester is granted the same way in both builds.
module l2_arbiter #(
  parameter int s_line = 256,
  parameter int s_mask = s_line / 8
) (
  input  logic              clk,
  input  logic              rst_n,

  // L1 instruction cache (read-only)
  input  logic [31:0]       i_address,
  input  logic              i_read,
  output logic              i_resp,
  output logic [s_line-1:0] i_rdata256,

  // L1 data cache (reads and full-line writebacks)
  input  logic [31:0]       d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [s_line-1:0] d_wdata256,
  input  logic [s_mask-1:0] d_byte_enable256,
  output logic              d_resp,
  output logic [s_line-1:0] d_rdata256,

  // L2 request port
  output logic [31:0]       mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [s_line-1:0] mem_wdata256,
  output logic [s_mask-1:0] mem_byte_enable256,
  input  logic              mem_resp,
  input  logic [s_line-1:0] mem_rdata256
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  state_e            state_q;
  owner_e            owner_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [31:0]       mem_address_q;
  logic [s_line-1:0] mem_wdata_q;
  logic [s_mask-1:0] mem_be_q;
  logic              i_resp_q;
  logic              d_resp_q;
  logic [s_line-1:0] i_rdata_q;
  logic [s_line-1:0] d_rdata_q;

  // Request that would be latched if a grant happens at this edge
  logic              d_req;
  logic              any_req;
  owner_e            owner_d;
  logic              write_d;
  logic [31:0]       address_d;
  logic [s_line-1:0] wdata_d;
  logic [s_mask-1:0] be_d;

`ifdef L2_ARB_ROUND_ROBIN_EN
  owner_e            last_grant_q;
`endif

  assign d_req   = d_read | d_write;
  assign any_req = d_req | i_read;

  // Arbitrate between I and D and shape the winner's L2 request.
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    owner_d   = OWN_I;
    write_d   = 1'b0;
    address_d = i_address;
    wdata_d   = '0;
    be_d      = '1;

`ifdef L2_ARB_ROUND_ROBIN_EN
    if (d_req && i_read) begin
      owner_d = (last_grant_q == OWN_D) ? OWN_I : OWN_D;
    end else if (d_req) begin
      owner_d = OWN_D;
    end else begin
      owner_d = OWN_I;
    end
`else
    if (d_req) begin
      owner_d = OWN_D;
    end
`endif

    if (owner_d == OWN_D) begin
      address_d = d_address;
      // A writeback wins over a read when the D-side raises both.
      if (d_write) begin
        write_d = 1'b1;
        wdata_d = d_wdata256;
        be_d    = d_byte_enable256;
      end
    end
  end

  // Transaction FSM: latch on grant, hold the L2 request, pulse resp for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= OWN_I;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      i_resp_q      <= 1'b0;
      d_resp_q      <= 1'b0;
      // NOTE: the returned-data registers are reset as well, because their value is visible on the ports right after reset.
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        IDLE: begin
          // Request lines are looked at only here; mem_resp is ignored.
          if (any_req) begin
            owner_q       <= owner_d;
            mem_read_q    <= ~write_d;
            mem_write_q   <= write_d;
            mem_address_q <= address_d;
            mem_wdata_q   <= wdata_d;
            mem_be_q      <= be_d;
            state_q       <= SERVE;
          end
        end

        SERVE: begin
          if (mem_resp) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (owner_q == OWN_D) begin
              d_resp_q <= 1'b1;
              // A writeback returns no data, so d_rdata256 keeps its old line.
              if (!mem_write_q) begin
                d_rdata_q <= mem_rdata256;
              end
            end else begin
              i_resp_q  <= 1'b1;
              i_rdata_q <= mem_rdata256;
            end
            state_q <= RESP;
          end
        end

        RESP: begin
          i_resp_q <= 1'b0;
          d_resp_q <= 1'b0;
          state_q  <= IDLE;
        end

        default: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          i_resp_q    <= 1'b0;
          d_resp_q    <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

`ifdef L2_ARB_ROUND_ROBIN_EN
  // Remember the most recent winner so a later tie goes to the other port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= OWN_I;
    end else if (state_q == IDLE && any_req) begin
      last_grant_q <= owner_d;
    end
  end
`endif

  assign mem_read           = mem_read_q;
  assign mem_write          = mem_write_q;
  assign mem_address        = mem_address_q;
  assign mem_wdata256       = mem_wdata_q;
  assign mem_byte_enable256 = mem_be_q;
  assign i_resp             = i_resp_q;
  assign d_resp             = d_resp_q;
  assign i_rdata256         = i_rdata_q;
  assign d_rdata256         = d_rdata_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter
// Table of single transactions run through a scoreboard, followed by
// hand-written sequences for the multi-cycle corner cases.
// Covered corners: simultaneous I/D requests, inputs changing mid-SERVE,
// a spurious mem_resp in IDLE, and reset during SERVE.
// Define L2_ARB_ROUND_ROBIN_EN here too when building the round-robin variant.
module tb_l2_arbiter;
  localparam int LW = 256;
  localparam int MW = 32;
  localparam int NV = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   i_address;
  logic          i_read;
  logic          i_resp;
  logic [LW-1:0] i_rdata256;
  logic [31:0]   d_address;
  logic          d_read;
  logic          d_write;
  logic [LW-1:0] d_wdata256;
  logic [MW-1:0] d_byte_enable256;
  logic          d_resp;
  logic [LW-1:0] d_rdata256;
  logic [31:0]   mem_address;
  logic          mem_read;
  logic          mem_write;
  logic [LW-1:0] mem_wdata256;
  logic [MW-1:0] mem_byte_enable256;
  logic          mem_resp;
  logic [LW-1:0] mem_rdata256;

  l2_arbiter #(.s_line(LW), .s_mask(MW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_address          (i_address),
    .i_read             (i_read),
    .i_resp             (i_resp),
    .i_rdata256         (i_rdata256),
    .d_address          (d_address),
    .d_read             (d_read),
    .d_write            (d_write),
    .d_wdata256         (d_wdata256),
    .d_byte_enable256   (d_byte_enable256),
    .d_resp             (d_resp),
    .d_rdata256         (d_rdata256),
    .mem_address        (mem_address),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_wdata256       (mem_wdata256),
    .mem_byte_enable256 (mem_byte_enable256),
    .mem_resp           (mem_resp),
    .mem_rdata256       (mem_rdata256)
  );

  always #5 clk = ~clk;

  // One requester transaction: what is driven and how the L2 model answers
  typedef struct {
    logic          is_d;
    logic          rd;
    logic          wr;
    logic [31:0]   addr;
    logic [LW-1:0] wdata;
    logic [MW-1:0] be;
    int            wait_n;
    logic [LW-1:0] rdata;
  } vec_t;

  // What the L2 port must show for that transaction
  typedef struct {
    logic          owner_d;
    logic          wr;
    logic [31:0]   addr;
    logic [LW-1:0] wdata;
    logic [MW-1:0] be;
    int            wait_n;
    logic [LW-1:0] rdata;
  } exp_t;

  exp_t          sb_q[$];
  vec_t          vecs[NV];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [LW-1:0] model_i_rdata;
  logic [LW-1:0] model_d_rdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t make_exp(input vec_t v);
    exp_t e;
    e.owner_d = v.is_d;
    e.wr      = v.is_d & v.wr;
    e.addr    = v.addr;
    e.wdata   = v.wdata;
    e.be      = e.wr ? v.be : '1;
    e.wait_n  = v.wait_n;
    e.rdata   = v.rdata;
    return e;
  endfunction

  task automatic drive_req(input vec_t v);
    if (v.is_d) begin
      d_address        = v.addr;
      d_read           = v.rd;
      d_write          = v.wr;
      d_wdata256       = v.wdata;
      d_byte_enable256 = v.be;
    end else begin
      i_address = v.addr;
      i_read    = 1'b1;
    end
    sb_q.push_back(make_exp(v));
  endtask

  task automatic drop_req(input logic is_d);
    if (is_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
  endtask

  // Step until the DUT raises an L2 request; budget 0 means it must already be up.
  task automatic wait_grant(input string name, input int budget);
    int n;
    n = 0;
    while (!(mem_read || mem_write) && n < budget) begin
      step();
      n++;
    end
    n_tests++;
    if (!(mem_read || mem_write)) begin
      n_fail++;
      $display("FAIL %s: no L2 request after %0d extra cycles", name, budget);
    end
  endtask

  // DUT is in SERVE: check the held request, answer it, then check the RESP cycle.
  task automatic serve(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: L2 request with empty scoreboard", name);
      return;
    end
    e = sb_q.pop_front();
    for (int c = 1; c <= e.wait_n; c++) begin
      check({name, ".mem_read"},  mem_read,  !e.wr);
      check({name, ".mem_write"}, mem_write, e.wr);
      check({name, ".mem_address"}, mem_address, e.addr);
      check({name, ".mem_be"}, mem_byte_enable256, e.be);
      if (e.wr) check({name, ".mem_wdata"}, mem_wdata256, e.wdata);
      check({name, ".resp_early"}, {i_resp, d_resp}, 2'b00);
      if (c == e.wait_n) begin
        mem_resp     = 1'b1;
        mem_rdata256 = e.rdata;
      end
      step();
    end
    // Different data after the response edge exposes a late capture.
    mem_resp     = 1'b0;
    mem_rdata256 = ~e.rdata;
    if (!e.wr) begin
      if (e.owner_d) model_d_rdata = e.rdata;
      else           model_i_rdata = e.rdata;
    end
    check({name, ".i_resp"}, i_resp, !e.owner_d);
    check({name, ".d_resp"}, d_resp, e.owner_d);
    check({name, ".req_after_resp"}, {mem_read, mem_write}, 2'b00);
    check({name, ".i_rdata"}, i_rdata256, model_i_rdata);
    check({name, ".d_rdata"}, d_rdata256, model_d_rdata);
  endtask

  task automatic check_quiet(input string name);
    check({name, ".resp"}, {i_resp, d_resp}, 2'b00);
    check({name, ".req"}, {mem_read, mem_write}, 2'b00);
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".mem_rw"}, {mem_read, mem_write}, 2'b00);
    check({name, ".mem_address"}, mem_address, 32'h0);
    check({name, ".mem_wdata"}, mem_wdata256, '0);
    check({name, ".mem_be"}, mem_byte_enable256, '0);
    check({name, ".resp"}, {i_resp, d_resp}, 2'b00);
    check({name, ".i_rdata"}, i_rdata256, '0);
    check({name, ".d_rdata"}, d_rdata256, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst_n            = 1'b0;
    i_address        = '0;
    i_read           = 1'b0;
    d_address        = '0;
    d_read           = 1'b0;
    d_write          = 1'b0;
    d_wdata256       = '0;
    d_byte_enable256 = '0;
    mem_resp         = 1'b0;
    mem_rdata256     = '0;
    model_i_rdata    = '0;
    model_d_rdata    = '0;

    vecs[0] = '{is_d: 1'b0, rd: 1'b1, wr: 1'b0, addr: 32'h0000_1040, wdata: '0,
                be: '0, wait_n: 4, rdata: {32{8'hA5}}};
    vecs[1] = '{is_d: 1'b1, rd: 1'b0, wr: 1'b1, addr: 32'h8000_0020, wdata: {16{16'h1234}},
                be: 32'hFFFF_FFFF, wait_n: 2, rdata: {8{32'hDEAD_BEEF}}};
    vecs[2] = '{is_d: 1'b1, rd: 1'b1, wr: 1'b0, addr: 32'h0000_0200, wdata: {8{32'h5555_0000}},
                be: 32'h0000_0001, wait_n: 1, rdata: {8{32'h0BAD_F00D}}};
    vecs[3] = '{is_d: 1'b1, rd: 1'b0, wr: 1'b1, addr: 32'h0000_3000, wdata: {4{64'hCAFE_0123_4567_89AB}},
                be: 32'h0000_00F0, wait_n: 3, rdata: {8{32'h1111_2222}}};
    vecs[4] = '{is_d: 1'b1, rd: 1'b1, wr: 1'b1, addr: 32'h0000_4040, wdata: {8{32'h7777_8888}},
                be: 32'h0F0F_0F0F, wait_n: 1, rdata: {8{32'h3333_4444}}};
    vecs[5] = '{is_d: 1'b0, rd: 1'b1, wr: 1'b0, addr: 32'hFFFF_FFC0, wdata: '0,
                be: '0, wait_n: 2, rdata: {8{32'h0123_4567}}};
    vecs[6] = '{is_d: 1'b1, rd: 1'b1, wr: 1'b0, addr: 32'h0000_0600, wdata: '0,
                be: '0, wait_n: 1, rdata: {8{32'h89AB_CDEF}}};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 rst_n = 1'b1;
    step();
    check_quiet("idle_after_reset");

    // Single transactions from the table
    for (int i = 0; i < NV; i++) begin
      drive_req(vecs[i]);
      step();
      wait_grant($sformatf("vec%0d.latency", i), 0);
      serve($sformatf("vec%0d", i));
      drop_req(vecs[i].is_d);
      step();
      check_quiet($sformatf("vec%0d.idle", i));
    end

    // Simultaneous I and D reads with a zero-wait L2; the last grant was D.
    i_address = 32'h0000_0100;
    i_read    = 1'b1;
    d_address = 32'h0000_0200;
    d_read    = 1'b1;
    d_write   = 1'b0;
`ifdef L2_ARB_ROUND_ROBIN_EN
    sb_q.push_back('{owner_d: 1'b0, wr: 1'b0, addr: 32'h100, wdata: '0, be: '1, wait_n: 1, rdata: {8{32'hAAAA_0001}}});
    sb_q.push_back('{owner_d: 1'b1, wr: 1'b0, addr: 32'h200, wdata: '0, be: '1, wait_n: 1, rdata: {8{32'hBBBB_0002}}});
`else
    sb_q.push_back('{owner_d: 1'b1, wr: 1'b0, addr: 32'h200, wdata: '0, be: '1, wait_n: 1, rdata: {8{32'hBBBB_0002}}});
    sb_q.push_back('{owner_d: 1'b0, wr: 1'b0, addr: 32'h100, wdata: '0, be: '1, wait_n: 1, rdata: {8{32'hAAAA_0001}}});
`endif
    step();
    wait_grant("sim.first", 0);
    serve("sim.first");
`ifdef L2_ARB_ROUND_ROBIN_EN
    drop_req(1'b0);
`else
    drop_req(1'b1);
`endif
    step();
    check_quiet("sim.gap");
    step();
    wait_grant("sim.second", 0);
    serve("sim.second");
    drop_req(1'b0);
    drop_req(1'b1);
    step();
    check_quiet("sim.idle");

    // D inputs change while the request is being served.
    v = '{is_d: 1'b1, rd: 1'b1, wr: 1'b0, addr: 32'h0000_0040, wdata: '0,
          be: '0, wait_n: 4, rdata: {8{32'h4040_4040}}};
    drive_req(v);
    step();
    wait_grant("hold.latency", 0);
    d_address        = 32'h0000_0080;
    d_write          = 1'b1;
    d_wdata256       = '1;
    d_byte_enable256 = 32'h0000_0001;
    serve("hold");
    drop_req(1'b1);
    step();
    check_quiet("hold.idle");

    // Spurious mem_resp in IDLE is ignored.
    mem_resp     = 1'b1;
    mem_rdata256 = {8{32'hF00D_F00D}};
    step();
    mem_resp = 1'b0;
    check_quiet("spurious.a");
    check("spurious.i_rdata", i_rdata256, model_i_rdata);
    check("spurious.d_rdata", d_rdata256, model_d_rdata);
    step();
    check_quiet("spurious.b");

    // Reset during a wait state abandons the transaction.
    i_address = 32'h0000_0300;
    i_read    = 1'b1;
    step();
    wait_grant("rst.latency", 0);
    step();
    check("rst.wait_state", mem_read, 1'b1);
    rst_n  = 1'b0;
    i_read = 1'b0;
    model_i_rdata = '0;
    model_d_rdata = '0;
    #1;
    check_all_zero("rst.async");
    step();
    check_all_zero("rst.held");
    #2 rst_n = 1'b1;
    step();
    check_quiet("rst.idle");

    // Re-issued request completes normally.
    v = '{is_d: 1'b0, rd: 1'b1, wr: 1'b0, addr: 32'h0000_0340, wdata: '0,
          be: '0, wait_n: 2, rdata: {8{32'h0300_0340}}};
    drive_req(v);
    step();
    wait_grant("reissue.latency", 0);
    serve("reissue");
    drop_req(1'b0);
    step();
    check_quiet("reissue.idle");

    check("scoreboard.empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
